// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 UART receiver with a first-word-fall-through receive FIFO.
//   The serial line is synchronised, each frame is sampled mid-bit, and
//   complete bytes with a good stop bit are stored for the core to read over
//   a valid/ready handshake. Framing and overrun errors are sticky.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   rx           serial input (asynchronous, idle high)
//   rx_data      head-of-FIFO byte, 8'h00 while empty
//   rx_valid     FIFO not empty
//   rx_ready     consumer accepts rx_data when rx_valid & rx_ready
//   fifo_count   number of stored bytes, 0..2**FIFO_AW
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: a good byte was dropped because the FIFO was full
//   err_clear    one-cycle pulse clearing both sticky flags
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_err,
    output logic               overrun_err,
    input  logic               err_clear
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0]   HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------- sync
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              push;
    logic              frame_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Re-check the line half a bit in: a short low pulse is noise.
                if (bit_cnt_q == HALF_M1) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a long break is
                // not mistaken for a stream of start bits.
                bit_cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    count_q;
    logic                pop, full, wr_en, overrun_set;

    assign pop         = rx_valid & rx_ready;
    assign full        = (count_q == DEPTH_C);
    // When full, a simultaneous pop frees the slot the push needs.
    assign wr_en       = push & (~full | pop);
    assign overrun_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_valid   = (count_q != '0);
    // Memory is not reset; mask it so an empty FIFO presents zero.
    assign rx_data    = rx_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;

    // -------------------------------------------------------- sticky flags
    logic frame_err_q, overrun_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            // A new event in the same cycle as err_clear keeps the flag set.
            if (frame_set)      frame_err_q <= 1'b1;
            else if (err_clear) frame_err_q <= 1'b0;
            if (overrun_set)    overrun_err_q <= 1'b1;
            else if (err_clear) overrun_err_q <= 1'b0;
        end
    end

    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [AW:0]   fifo_count;
    logic          frame_err;
    logic          overrun_err;
    logic          err_clear = 1'b0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue of bytes the receiver should hold,
    // plus the two sticky flags.
    logic [7:0] exp_q[$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted byte must be the next one the model expects.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: got byte 0x%02h, expected no byte", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got 0x%02h, expected 0x%02h", rx_data, e);
                end else begin
                    $display("pop  byte 0x%02h", rx_data);
                end
            end
        end
    end

    // Drive one 8N1 frame. bad_stop holds the stop bit low for two bit
    // times. pop_at_push raises rx_ready for exactly the cycle whose edge
    // samples the stop bit (start edge + 2 sync + 1 detect + H + 9*CPB).
    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit pop_at_push);
        $display("send byte 0x%02h bad_stop=%0d pop_at_push=%0d", b, bad_stop, pop_at_push);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        if (bad_stop) begin
            exp_ferr = 1'b1;
            rx = 1'b0;
            repeat (2 * CPB) tick();
            rx = 1'b1;
            repeat (CPB) tick();
        end else begin
            if (exp_q.size() < CAP || pop_at_push) exp_q.push_back(b);
            else                                   exp_ovr = 1'b1;
            rx = 1'b1;
            if (pop_at_push) begin
                repeat (H + 2) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
                repeat (CPB - H - 3) tick();
            end else begin
                repeat (CPB) tick();
            end
        end
        repeat (2) tick();
    endtask

    // Compare the observable state with the model while nothing is moving.
    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_count"},    int'(fifo_count),  exp_q.size());
        check({tag, "_valid"},    int'(rx_valid),    int'(exp_q.size() != 0));
        check({tag, "_frame"},    int'(frame_err),   int'(exp_ferr));
        check({tag, "_overrun"},  int'(overrun_err), int'(exp_ovr));
        tick();
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        rx_ready = 1'b0;
        check({tag, "_drained"}, exp_q.size(), 0);
        check_state(tag);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_valid"},   int'(rx_valid),    0);
        check({tag, "_count"},   int'(fifo_count),  0);
        check({tag, "_frame"},   int'(frame_err),   0);
        check({tag, "_overrun"}, int'(overrun_err), 0);
        check({tag, "_data"},    int'(rx_data),     0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        // ------------------------------------------------ reset
        repeat (4) tick();
        rst = 1'b0;
        check_reset_values("reset");
        repeat (CPB) tick();

        // ------------------------------------------------ basic bytes
        rx_ready = 1'b1;
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'hA3, 1'b0, 1'b0);
        rx_ready = 1'b0;
        check_state("basic");

        // ------------------------------------------------ glitches
        for (int g = 0; g < 3; g++) begin
            int len;
            len = $urandom_range(H - 2, 1);
            $display("glitch low for %0d cycles", len);
            rx = 1'b0;
            repeat (len) tick();
            rx = 1'b1;
            repeat (2 * CPB) tick();
        end
        check_state("glitch");

        // ------------------------------------------------ framing error
        send_byte(8'h3C, 1'b1, 1'b0);
        check_state("ferr");
        rx_ready = 1'b1;
        send_byte(8'h41, 1'b0, 1'b0);
        rx_ready = 1'b0;
        check_state("ferr_sticky");
        pulse_clear();
        check_state("ferr_clear");

        // ------------------------------------------------ overrun
        for (int i = 0; i <= CAP; i++) send_byte(8'(i), 1'b0, 1'b0);
        check_state("overrun");
        drain("overrun_drain");
        pulse_clear();
        check_state("ovr_clear");

        // ------------------------------------------------ pop on the full push
        for (int i = 0; i < CAP; i++) send_byte(8'($urandom_range(255, 0)), 1'b0, 1'b0);
        send_byte(8'hC7, 1'b0, 1'b1);
        check_state("full_pop");
        drain("full_pop_drain");

        // ------------------------------------------------ random traffic
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(255, 0)), 1'b0, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rx_ready = 1'($urandom_range(1, 0));
                    tick();
                end
            end
        join
        drain("random");

        // ------------------------------------------------ reset mid-frame
        send_byte(8'h21, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        check_state("pre_rst");
        $display("send byte 0xff aborted by reset in bit 4");
        rx = 1'b0;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (4 * CPB + H) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        check_reset_values("mid_rst");
        repeat (CPB) tick();
        rx_ready = 1'b1;
        send_byte(8'h12, 1'b0, 1'b0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
